pipe_hazard_ctrl: RTL

- Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Drives the write-enable and synchronous-clear controls of the decode, execute and memory pipe registers, plus the PC write-enable.
- Detects load-use hazards, branch-taken flushes, MFHI/MFLO reads during a busy multiply/divide unit, and an external freeze.
- Sequences the resulting bubbles and keeps a saturating stall-cycle counter.

---
 rtl/pipe_hazard_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS32 pipeline with load-use, MDU, branch and freeze handling
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 1,
    parameter int CNT_W             = 16
) (
    input  logic             i_clk,
    input  logic             i_a_rst,
    input  logic             i_s_rst,
    input  logic [31:0]      i_instr_dec,
    input  logic [31:0]      i_instr_exec,
    input  logic             i_branch_taken,
    input  logic             i_mdu_busy,
    input  logic             i_freeze,
    output logic             o_pc_we,
    output logic             o_we_dec,
    output logic             o_srst_dec,
    output logic             o_we_exec,
    output logic             o_srst_exec,
    output logic             o_we_mem,
    output logic             o_srst_mem,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [1:0]       o_state
);
    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] LSTALL = 2'd1;
    localparam logic [1:0] FLUSH  = 2'd2;
    localparam logic [1:0] MWAIT  = 2'd3;
    localparam logic [1:0] LS_INIT = 2'(LOAD_STALL_CYCLES > 1 ? LOAD_STALL_CYCLES - 2 : 0);
    localparam logic [1:0] BP_INIT = 2'(BRANCH_PENALTY > 1 ? BRANCH_PENALTY - 2 : 0);
    localparam logic [6:0] CTL_RST   = 7'b0010101;
    localparam logic [6:0] CTL_FRZ   = 7'b0000000;
    localparam logic [6:0] CTL_BR    = 7'b1111110;
    localparam logic [6:0] CTL_FL    = 7'b1111010;
    localparam logic [6:0] CTL_STALL = 7'b0001110;
    localparam logic [6:0] CTL_RUN   = 7'b1101010;
    logic [1:0]       state_q, state_d, cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [6:0]       ctl;
    logic             is_load, lu, mh, hz;
    assign is_load = i_instr_exec[31:26] inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
    assign lu = is_load && i_instr_exec[20:16] != 5'd0 &&
                (i_instr_dec[25:21] == i_instr_exec[20:16] || i_instr_dec[20:16] == i_instr_exec[20:16]);
    assign mh = i_instr_dec[31:26] == 6'h00 && (i_instr_dec[5:0] == 6'h10 || i_instr_dec[5:0] == 6'h12) && i_mdu_busy;
    assign hz = (state_q == RUN || state_q == MWAIT) && (lu || mh);
    assign {o_pc_we, o_we_dec, o_srst_dec, o_we_exec, o_srst_exec, o_we_mem, o_srst_mem} = ctl;
    assign o_stall_cnt = stall_cnt_q;
    assign o_state = state_q;
    always_comb begin
        ctl = (i_a_rst || i_s_rst)         ? CTL_RST :
              i_freeze                     ? CTL_FRZ :
              i_branch_taken               ? CTL_BR :
              state_q == FLUSH             ? CTL_FL :
              (state_q == LSTALL || hz)    ? CTL_STALL : CTL_RUN;
    end
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (i_s_rst) begin
            state_d = RUN;
            cnt_d = 2'd0;
            stall_cnt_d = '0;
        end else if (!i_freeze) begin
            if (!ctl[6] && stall_cnt_q != '1)
                stall_cnt_d = stall_cnt_q + 1'b1;
            if (i_branch_taken) begin
                state_d = BRANCH_PENALTY > 1 ? FLUSH : RUN;
                cnt_d = BP_INIT;
            end else if (state_q == FLUSH || state_q == LSTALL) begin
                state_d = cnt_q == 2'd0 ? RUN : state_q;
                cnt_d = cnt_q == 2'd0 ? 2'd0 : cnt_q - 2'd1;
            end else if (lu) begin
                state_d = LOAD_STALL_CYCLES > 1 ? LSTALL : RUN;
                cnt_d = LS_INIT;
            end else begin
                state_d = mh ? MWAIT : RUN;
                cnt_d = 2'd0;
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_a_rst) begin
        if (i_a_rst) begin
            state_q <= RUN;
            cnt_q <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule
